// File: rtl/ram_pkg.sv
// Shared defaults and state encoding for the single-port RAM with clear-on-reset sweep.
package ram_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 16;

    typedef enum logic [1:0] {
        CLEAR        = 2'd0,
        DONE_PENDING = 2'd1,
        RUN          = 2'd2
    } ram_state_t;

endpackage

// File: rtl/ram_core_sp.sv
// Plain inferred single-port array: synchronous write, registered read-first output, no reset.
module ram_core_sp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read and write in one process so a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_ram_256x16.sv
// 256x16 single-port RAM with post-reset zero sweep, ready flag and registered read.
module sync_ram_256x16
    import ram_pkg::*;
#(
    parameter int ADDR_W       = RAM_ADDR_W,
    parameter int DATA_W       = RAM_DATA_W,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    ram_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic              rd_vld_q, rd_vld_d;

    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ready_d    = ready_q;
        rd_vld_d   = 1'b0;
        core_we    = 1'b0;
        core_addr  = addr;
        core_wdata = data_in;

        case (state_q)
            CLEAR: begin
                core_we    = 1'b1;
                core_addr  = ptr_q;
                core_wdata = '0;
                ptr_d      = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            DONE_PENDING: begin
                state_d = RUN;
                ready_d = 1'b1;
            end
            RUN: begin
                core_we  = wea;
                rd_vld_d = 1'b1;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        // Reset must also block the array write that the current state would issue.
        if (rst) begin
            core_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR_ON_RST ? CLEAR : DONE_PENDING;
            ptr_q    <= '0;
            ready_q  <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ready_q  <= ready_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    ram_core_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .addr  (core_addr),
        .wdata (core_wdata),
        .rdata (core_rdata)
    );

    // The array output register has no reset, so mask it until a RUN-state read has landed.
    assign data_out = rd_vld_q ? core_rdata : '0;
    assign ready    = ready_q;

endmodule

// File: tb/tb_sync_ram_256x16.sv
// Scoreboard bench for sync_ram_256x16: reference array model, queued expected read data.
module tb_sync_ram_256x16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wea;
    logic [7:0]  addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model [256];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    sync_ram_256x16 dut (
        .clk      (clk),
        .rst      (rst),
        .wea      (wea),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One access cycle; the model is read before it is written (read-first).
    task automatic drive(input string tag, input logic we, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        wea     = we;
        addr    = a;
        data_in = d;
        exp_q.push_back(model[a]);
        if (we) model[a] = d;
        @(posedge clk);
        #1;
        wea = 1'b0;
        chk(tag, data_out, exp_q.pop_front());
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        wea = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_dout", data_out, 16'h0000);
            chk("rst_ready", ready, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input bit poke, input int reset_at);
        int cnt = 0;
        bit restarted = 1'b0;
        if (poke) begin
            wea     = 1'b1;
            addr    = 8'h03;
            data_in = 16'hFFFF;
        end
        while (!ready && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!restarted && cnt == reset_at) begin
                restarted = 1'b1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("midsweep_ready", ready, 1'b0);
                chk("midsweep_dout", data_out, 16'h0000);
                rst = 1'b0;
                cnt = 0;
            end
            if (cnt == 128) chk("sweep_dout", data_out, 16'h0000);
            if (cnt == 200) wea = 1'b0;
        end
        wea = 1'b0;
        chk("ready_latency", cnt, 256);
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    endtask

    initial begin
        rst     = 1'b1;
        wea     = 1'b0;
        addr    = 8'h00;
        data_in = 16'h0000;
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;

        // Reset then idle
        do_reset(3);
        wait_ready(1'b0, -1);
        drive("idle_00", 1'b0, 8'h00, 16'h0);
        drive("idle_7f", 1'b0, 8'h7F, 16'h0);
        drive("idle_ff", 1'b0, 8'hFF, 16'h0);

        // Write / readback
        drive("wr_05", 1'b1, 8'h05, 16'h1234);
        drive("wr_ff", 1'b1, 8'hFF, 16'hBEEF);
        drive("rd_05", 1'b0, 8'h05, 16'h0);
        drive("rd_ff", 1'b0, 8'hFF, 16'h0);
        chk("rd_ff_value", model[8'hFF], 16'hBEEF);

        // Read-during-write, read-first
        drive("rdw_init", 1'b1, 8'h10, 16'hAAAA);
        drive("rdw_old", 1'b1, 8'h10, 16'h5555);
        drive("rdw_new", 1'b0, 8'h10, 16'h0);

        // Incrementing scan with wrap
        for (int i = 0; i < 256; i++) drive("scan_wr", 1'b1, 8'(i), 16'(i * 3));
        for (int i = 0; i <= 256; i++) begin
            drive("scan_rd", 1'b0, 8'(i), 16'h0);
            drive("scan_rd", 1'b0, 8'(i), 16'h0);
        end

        // Reset after RUN writes, sweep lockout and a reset at sweep pointer 100
        do_reset(2);
        wait_ready(1'b1, 100);
        drive("lock_03", 1'b0, 8'h03, 16'h0);
        drive("clr_05", 1'b0, 8'h05, 16'h0);
        drive("clr_10", 1'b0, 8'h10, 16'h0);
        drive("clr_20", 1'b0, 8'h20, 16'h0);
        drive("clr_ff", 1'b0, 8'hFF, 16'h0);
        chk("ready_hold", ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
